apu_frame_sequencer: RTL and testbench
======================================

Name: apu_frame_sequencer

Overview:
- Frame sequencer that generates the quarter-frame and half-frame clock pulses for the APU channels.
- Its outputs drive the triangle channel's linear-counter clock and length-counter clock, and the pulse/noise envelope and sweep clocks.
- It implements the $4017 mode/IRQ-inhibit register, the 4-step/5-step sequence and the frame IRQ flag.
- It sits directly upstream of the triangle channel on the same CPU-rate clk.

Parameters:
- STEP1, 7457, cycle index of step 1 (quarter)
- STEP2, 14913, cycle index of step 2 (quarter+half)
- STEP3, 22371, cycle index of step 3 (quarter)
- STEP4, 29829, cycle index of step 4 (4-step: quarter+half+IRQ; 5-step: nothing)
- STEP5, 37281, cycle index of step 5 (5-step only: quarter+half)
- WRITE_DELAY, 3, clk cycles from a $4017 write to divider restart (legal range 1..7)
- CNT_W, 16, width of the cycle counter (must hold STEP5)

Ports:
- clk  input  1  CPU-rate clock, rising-edge
- reset_n  input  1  asynchronous active-low reset
- wr_en  input  1  one-cycle strobe: CPU write to $4017
- wr_data  input  8  write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit; other bits ignored
- irq_ack  input  1  one-cycle strobe: CPU read of $4015, clears frame IRQ
- quarter_frame  output  1  one-cycle pulse; feeds the linear counter and envelope clocks
- half_frame  output  1  one-cycle pulse; feeds the length counter and sweep clocks
- frame_irq  output  1  frame interrupt flag, level
- mode  output  1  current sequence mode, for status/debug

Behaviour:
- Reset (async, reset_n low):
  - cnt=0, mode=0, inhibit=0, frame_irq=0, quarter_frame=0, half_frame=0, no write pending.
  - Counting starts on the first rising edge after reset_n deasserts.
  - Reset mid-sequence aborts the sequence and any pending write; no pulse is emitted on release.
- cnt is the cycle index since the last divider restart. It increments by 1 per clk.
- Wrap rules:
  - 4-step (mode=0): in the cycle where cnt==STEP4, the next value is 0.
  - 5-step (mode=1): in the cycle where cnt==STEP5, the next value is 0.
- All outputs are registered. Each pulse is high for exactly the one cycle in which cnt equals the step index.
- 4-step mode:
  - quarter_frame at STEP1, STEP2, STEP3, STEP4.
  - half_frame at STEP2, STEP4.
  - frame_irq is set on the edge ending the cycle cnt==STEP4, if inhibit=0.
- 5-step mode:
  - quarter_frame at STEP1, STEP2, STEP3, STEP5.
  - half_frame at STEP2, STEP5.
  - Nothing happens at STEP4. frame_irq is never set.
- frame_irq stays high until one of the following occurs:
  - irq_ack is asserted;
  - a write sets inhibit=1;
  - reset.
- Priority rules for frame_irq:
  - A set and an irq_ack in the same cycle: the set wins, so frame_irq stays 1.
  - An inhibit-setting write in the same cycle as a set: the clear wins.
- $4017 write:
  - On the wr_en edge, mode and inhibit load from wr_data[7:6] immediately.
  - If inhibit becomes 1, frame_irq clears on that edge.
  - A restart is scheduled WRITE_DELAY cycles later. The sequence keeps running with the new mode until then.
  - Example (WRITE_DELAY=3): wr_en sampled at edge E, so the restart edge is E+3 and cnt=0 in the cycle after edge E+3.
  - On the restart edge, cnt is forced to 0.
  - If mode=1, quarter_frame and half_frame pulse for one cycle, the cycle with cnt=0 after the restart. This is the immediate clock.
  - If mode=0, no immediate pulse.
  - A step decode that coincides with the restart edge still fires. No pulse is ever longer than one cycle.
- A second write while a restart is pending reloads mode/inhibit and restarts the delay count. Only one restart occurs, timed from the last write.
- The step decode is evaluated against the post-write mode on every cycle.

Test Plan:
Benches override the step parameters to STEP1=10, STEP2=20, STEP3=30, STEP4=40, STEP5=50, WRITE_DELAY=3.
- Reset release, no writes, run 100 cycles -> quarter at cnt 10,20,30,40; half at 20,40; frame_irq rises after cnt 40 and stays high; the pattern repeats (cnt 0 follows 40).
- frame_irq high, irq_ack pulse -> frame_irq 0 on the next edge; the next set occurs at the next cnt==40. Also drive ack on the exact set edge -> frame_irq remains 1.
- Write 0x80 at cnt 15 -> quarter+half pulse together 3 cycles later with cnt=0; subsequent quarter at 10,20,30,50, half at 20,50, none at 40; frame_irq never rises over 200 cycles.
- frame_irq high, write 0x40 -> frame_irq 0 on the write edge; after the restart, cnt==40 passes with frame_irq still 0. Write 0x00 -> the IRQ sets again at the next cnt==40.
- Write 0x80, then write 0x80 again 2 cycles later -> exactly one immediate pulse pair, 3 cycles after the second write.
- Assert reset_n low asynchronously (mid-cycle) at cnt 25 in 5-step mode -> all outputs 0 immediately and mode=0; after release, 4-step timing from cnt 0 with no immediate pulse.

Source files
------------

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: $4017 mode/inhibit register, 4/5-step divider,
// quarter/half-frame clock pulses and the frame IRQ flag.
module apu_frame_sequencer #(
  parameter int unsigned STEP1       = 7457,
  parameter int unsigned STEP2       = 14913,
  parameter int unsigned STEP3       = 22371,
  parameter int unsigned STEP4       = 29829,
  parameter int unsigned STEP5       = 37281,
  parameter int unsigned WRITE_DELAY = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic       mode
);

  localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);
  localparam logic [2:0]       WD = 3'(WRITE_DELAY);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       pend;
  logic             inhibit;
  logic             eff_mode;
  logic             eff_inh;
  logic             restart;
  logic             wrap;
  logic             q_nxt;
  logic             h_nxt;
  logic             irq_set;

  // Decode runs against the mode that will be in force next cycle, so a
  // write takes effect on the sequence from its own edge onward.
  always_comb begin
    eff_mode = wr_en ? wr_data[7] : mode;
    eff_inh  = wr_en ? wr_data[6] : inhibit;
    restart  = !wr_en && (pend == 3'd1);
    // >= keeps a 5-to-4-step switch past STEP4 from running to counter overflow
    wrap     = eff_mode ? (cnt >= S5) : (cnt >= S4);
    cnt_nxt  = (restart || wrap) ? '0 : cnt + CNT_W'(1);
    q_nxt    = (cnt_nxt == S1) || (cnt_nxt == S2) || (cnt_nxt == S3) ||
               (eff_mode ? (cnt_nxt == S5) : (cnt_nxt == S4)) ||
               (restart && eff_mode);
    h_nxt    = (cnt_nxt == S2) ||
               (eff_mode ? (cnt_nxt == S5) : (cnt_nxt == S4)) ||
               (restart && eff_mode);
    irq_set  = (cnt == S4) && !eff_mode && !eff_inh;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      pend          <= '0;
      mode          <= 1'b0;
      inhibit       <= 1'b0;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      frame_irq     <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      mode          <= eff_mode;
      inhibit       <= eff_inh;
      quarter_frame <= q_nxt;
      half_frame    <= h_nxt;
      if (wr_en)
        pend <= WD;
      else if (pend != 3'd0)
        pend <= pend - 3'd1;
      // Inhibit clear beats a set; a set beats an ack.
      if (wr_en && wr_data[6])
        frame_irq <= 1'b0;
      else if (irq_set)
        frame_irq <= 1'b1;
      else if (irq_ack)
        frame_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed table-driven bench for apu_frame_sequencer with shortened steps
// (10/20/30/40/50, write delay 3). Cycle k is the interval after edge k.
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       irq_ack;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;
  logic       mode;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  apu_frame_sequencer #(
    .STEP1(10), .STEP2(20), .STEP3(30), .STEP4(40), .STEP5(50),
    .WRITE_DELAY(3), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .irq_ack(irq_ack), .quarter_frame(quarter_frame), .half_frame(half_frame),
    .frame_irq(frame_irq), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    bit          chk;
    logic [3:0]  exp;   // {quarter, half, irq, mode}
    bit          wr;
    logic [7:0]  data;
    bit          ack;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t c(int unsigned cyc, logic [3:0] exp);
    vec_t v;
    v.cyc = cyc; v.chk = 1'b1; v.exp = exp; v.wr = 1'b0; v.data = 8'h00; v.ack = 1'b0;
    return v;
  endfunction

  function automatic vec_t w(int unsigned cyc, logic [7:0] data);
    vec_t v;
    v.cyc = cyc; v.chk = 1'b0; v.exp = 4'h0; v.wr = 1'b1; v.data = data; v.ack = 1'b0;
    return v;
  endfunction

  function automatic vec_t a(int unsigned cyc);
    vec_t v;
    v.cyc = cyc; v.chk = 1'b0; v.exp = 4'h0; v.wr = 1'b0; v.data = 8'h00; v.ack = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input int unsigned k, input logic [3:0] exp);
    logic [3:0] act;
    act = {quarter_frame, half_frame, frame_irq, mode};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got q/h/irq/mode=%b, expected %b", name, k, act, exp);
    end
  endtask

  initial begin
    int unsigned idx;
    reset_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; irq_ack = 1'b0;

    // 4-step free run and IRQ set/ack
    tbl.push_back(c(9,   4'b0000)); tbl.push_back(c(10,  4'b1000));
    tbl.push_back(c(11,  4'b0000)); tbl.push_back(c(20,  4'b1100));
    tbl.push_back(c(30,  4'b1000)); tbl.push_back(c(40,  4'b1100));
    tbl.push_back(c(41,  4'b0010)); tbl.push_back(c(51,  4'b1010));
    tbl.push_back(c(81,  4'b1110)); tbl.push_back(c(90,  4'b0010));
    tbl.push_back(a(90));           tbl.push_back(c(91,  4'b0000));
    tbl.push_back(c(122, 4'b1100)); tbl.push_back(c(123, 4'b0010));
    tbl.push_back(a(130));          tbl.push_back(c(131, 4'b0000));
    // ack on the set edge: set wins
    tbl.push_back(c(163, 4'b1100)); tbl.push_back(a(163));
    tbl.push_back(c(164, 4'b0010)); tbl.push_back(a(170));
    tbl.push_back(c(171, 4'b0000));
    // write 0x80 at cnt 15 -> 5-step with immediate clock
    tbl.push_back(c(179, 4'b0000)); tbl.push_back(w(179, 8'h80));
    tbl.push_back(c(180, 4'b0001)); tbl.push_back(c(182, 4'b0001));
    tbl.push_back(c(183, 4'b1101)); tbl.push_back(c(184, 4'b0001));
    tbl.push_back(c(193, 4'b1001)); tbl.push_back(c(203, 4'b1101));
    tbl.push_back(c(213, 4'b1001)); tbl.push_back(c(223, 4'b0001));
    tbl.push_back(c(224, 4'b0001)); tbl.push_back(c(233, 4'b1101));
    tbl.push_back(c(234, 4'b0001)); tbl.push_back(c(284, 4'b1101));
    tbl.push_back(c(380, 4'b0001));
    // back to 4-step: no immediate clock, restart moves the steps
    tbl.push_back(c(390, 4'b0001)); tbl.push_back(w(390, 8'h00));
    tbl.push_back(c(391, 4'b0000)); tbl.push_back(c(394, 4'b0000));
    tbl.push_back(c(404, 4'b1000)); tbl.push_back(c(434, 4'b1100));
    tbl.push_back(c(435, 4'b0010));
    // inhibit write clears IRQ and blocks the next set
    tbl.push_back(w(440, 8'h40));   tbl.push_back(c(441, 4'b0000));
    tbl.push_back(c(484, 4'b1100)); tbl.push_back(c(485, 4'b0000));
    tbl.push_back(w(490, 8'h00));   tbl.push_back(c(534, 4'b1100));
    tbl.push_back(c(535, 4'b0010)); tbl.push_back(a(550));
    tbl.push_back(c(551, 4'b0000));
    // inhibit write on the set edge: clear wins
    tbl.push_back(c(575, 4'b1100)); tbl.push_back(w(575, 8'h40));
    tbl.push_back(c(576, 4'b0000)); tbl.push_back(c(579, 4'b0000));
    // double write: one immediate clock, timed from the second write
    tbl.push_back(w(600, 8'h80));   tbl.push_back(c(602, 4'b0001));
    tbl.push_back(w(602, 8'h80));   tbl.push_back(c(604, 4'b0001));
    tbl.push_back(c(605, 4'b0001)); tbl.push_back(c(606, 4'b1101));
    tbl.push_back(c(607, 4'b0001)); tbl.push_back(c(631, 4'b0001));

    repeat (3) @(posedge clk);
    #1 check("reset_state", 0, 4'b0000);
    @(negedge clk) reset_n = 1'b1;

    idx = 0;
    for (int unsigned k = 1; k <= 631; k++) begin
      @(posedge clk);
      #1;
      wr_en = 1'b0; wr_data = 8'h00; irq_ack = 1'b0;
      while (idx < tbl.size() && tbl[idx].cyc == k) begin
        if (tbl[idx].chk) check("table", k, tbl[idx].exp);
        if (tbl[idx].wr) begin wr_en = 1'b1; wr_data = tbl[idx].data; end
        if (tbl[idx].ack) irq_ack = 1'b1;
        idx++;
      end
    end

    // asynchronous reset mid-cycle at cnt 25 in 5-step mode
    #3 reset_n = 1'b0;
    #1 check("async_reset", 631, 4'b0000);
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 0, 4'b0000);
    @(negedge clk) reset_n = 1'b1;
    for (int unsigned k = 1; k <= 41; k++) begin
      @(posedge clk);
      #1;
      case (k)
        1:  check("post_reset_no_imm", k, 4'b0000);
        10: check("post_reset_q10", k, 4'b1000);
        20: check("post_reset_qh20", k, 4'b1100);
        40: check("post_reset_qh40", k, 4'b1100);
        41: check("post_reset_irq", k, 4'b0010);
        default: ;
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
